// File: rtl/board_mem_loader_pkg.sv
// Shared definitions for the switch-driven memory loader and the display path.
package board_mem_loader_pkg;

    // Loader sequencing states; READBACK is only reachable in readback builds.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_READBACK = 2'd2,
        ST_RUN      = 2'd3
    } loader_state_t;

    // Display word is {word, valid}; the valid flag sits in the LSB.
    localparam int DISP_W       = 33;
    localparam int DISP_VLD_BIT = 0;

    // Pack a 32-bit word into a valid display value.
    function automatic logic [DISP_W-1:0] make_disp(input logic [31:0] word);
        logic [DISP_W-1:0] d;
        d = {word, 1'b0};
        d[DISP_VLD_BIT] = 1'b1;
        return d;
    endfunction

endpackage

// File: rtl/board_mem_loader_if.sv
// Board-side bundle for the loader: switches, buttons, memory write port, display.
interface board_mem_loader_if #(
    parameter int ADDR_W = 6
);
    import board_mem_loader_pkg::*;

    logic [31:0]       sw;
    logic              btn_addr;
    logic              btn_write;
    logic              btn_run;
    logic [31:0]       mem_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic [DISP_W-1:0] disp_data;
    logic [ADDR_W:0]   wr_count;
    logic              err;

    // The loader consumes operator inputs and owns the memory/display outputs.
    modport loader (
        input  sw, btn_addr, btn_write, btn_run, mem_rdata,
        output mem_we, mem_addr, mem_wdata, cpu_hold, disp_data, wr_count, err
    );

    // The board side (buttons, memory, display) is the mirror image.
    modport board (
        output sw, btn_addr, btn_write, btn_run, mem_rdata,
        input  mem_we, mem_addr, mem_wdata, cpu_hold, disp_data, wr_count, err
    );

endinterface

// File: rtl/board_mem_loader_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, rising-edge pulse.
module btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_evt
);
    localparam int              CNT_W    = $clog2(DEB_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_level_d;
    logic             r_evt;
    logic             w_raw;

    assign w_raw = r_sync[1];
    assign o_evt = r_evt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_sync <= 2'b00;
        else       r_sync <= {r_sync[0], i_btn};
    end

    // Flip the debounced level only after DEB_CYCLES consecutive samples at the new level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (w_raw == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_level <= w_raw;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Registered one-cycle pulse on each rising edge of the debounced level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_level_d <= 1'b0;
            r_evt     <= 1'b0;
        end else begin
            r_level_d <= r_level;
            r_evt     <= r_level & ~r_level_d;
        end
    end

endmodule

// File: rtl/board_mem_loader.sv
// Switch-driven instruction/data memory loader that holds the CPU until run is pressed.
// Optional feature: define LOADER_READBACK_EN to verify each written word by reading it back.
module board_mem_loader
    import board_mem_loader_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int DEB_CYCLES = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    board_mem_loader_if.loader  bus
);
    localparam logic [ADDR_W:0] WR_MAX = {1'b1, {ADDR_W{1'b0}}};

    loader_state_t     r_state;
    logic              r_hold;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [DISP_W-1:0] r_disp;
    logic [ADDR_W:0]   r_cnt;
    logic              w_evt_addr;
    logic              w_evt_write;
    logic              w_evt_run;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_addr (
        .i_clk(i_clk), .i_rst(i_rst), .i_btn(bus.btn_addr), .o_evt(w_evt_addr)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_write (
        .i_clk(i_clk), .i_rst(i_rst), .i_btn(bus.btn_write), .o_evt(w_evt_write)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .i_clk(i_clk), .i_rst(i_rst), .i_btn(bus.btn_run), .o_evt(w_evt_run)
    );

    assign bus.cpu_hold  = r_hold;
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.disp_data = r_disp;
    assign bus.wr_count  = r_cnt;

`ifdef LOADER_READBACK_EN
    logic r_err;
    assign bus.err = r_err;
`else
    logic w_unused_rdata;
    assign w_unused_rdata = ^bus.mem_rdata;
    assign bus.err = 1'b0;
`endif

    // Loader sequencer: events are only honoured in IDLE, so anything arriving mid-write is dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_hold  <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_disp  <= '0;
            r_cnt   <= '0;
`ifdef LOADER_READBACK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_evt_run) begin
                        r_hold  <= 1'b0;
                        r_state <= ST_RUN;
                    end else if (w_evt_write) begin
                        r_wdata <= bus.sw;
                        r_disp  <= make_disp(bus.sw);
                        r_we    <= 1'b1;
                        r_state <= ST_WRITE;
                    end else if (w_evt_addr) begin
                        r_addr <= bus.sw[ADDR_W-1:0];
                        r_disp <= make_disp(32'(bus.sw[ADDR_W-1:0]));
                    end
                end
                ST_WRITE: begin
                    // The memory captures the word on this edge; count it but let the count saturate.
                    if (r_cnt != WR_MAX) r_cnt <= r_cnt + 1'b1;
`ifdef LOADER_READBACK_EN
                    r_state <= ST_READBACK;
`else
                    r_addr  <= r_addr + 1'b1;
                    r_state <= ST_IDLE;
`endif
                end
`ifdef LOADER_READBACK_EN
                ST_READBACK: begin
                    // Address still points at the word just written, so rdata is its stored value.
                    if (bus.mem_rdata != r_wdata) r_err <= 1'b1;
                    r_addr  <= r_addr + 1'b1;
                    r_state <= ST_IDLE;
                end
`endif
                ST_RUN: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_mem_loader.sv
// Directed bench for board_mem_loader: table of address/write presses plus corner sequences.
module tb_board_mem_loader;
    localparam int ADDR_W   = 6;
    localparam int DEB      = 16;
    localparam int OP_ADDR  = 0;
    localparam int OP_WRITE = 1;

    typedef struct {
        int          op;
        logic [31:0] sw;
        logic [5:0]  exp_addr;
        logic [32:0] exp_disp;
        logic [6:0]  exp_cnt;
        logic [5:0]  mem_idx;
        logic [31:0] mem_val;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic corrupt = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   we_cnt = 0;
    int   we_wide = 0;
    logic we_prev = 1'b0;
    logic [31:0] mem [64];
    vec_t vecs [6];

    always #5 clk = ~clk;

    board_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    board_mem_loader #(.ADDR_W(ADDR_W), .DEB_CYCLES(DEB)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    // Memory model; optional fault forces bit 0 low on read.
    assign bus.mem_rdata = corrupt ? (mem[bus.mem_addr] & 32'hFFFF_FFFE) : mem[bus.mem_addr];

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 64; k++) mem[k] <= 32'h0;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
        if (bus.mem_we) we_cnt <= we_cnt + 1;
        if (bus.mem_we && we_prev) we_wide <= we_wide + 1;
        we_prev <= bus.mem_we;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_btns(input logic a, input logic w, input logic r);
        bus.btn_addr  = a;
        bus.btn_write = w;
        bus.btn_run   = r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_btns(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // which: 0 addr, 1 write, 2 run, 3 run+write together
    task automatic press(input int which, input logic [31:0] swv);
        @(negedge clk);
        bus.sw = swv;
        set_btns(which == 0, which == 1 || which == 3, which >= 2);
        repeat (22) @(negedge clk);
        set_btns(1'b0, 1'b0, 1'b0);
        repeat (22) @(negedge clk);
    endtask

    initial begin
        int lat;
        int we_base;
        bus.sw = 32'h0;
        set_btns(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset values
        chk("rst_cpu_hold", bus.cpu_hold, 1);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_disp", bus.disp_data, 0);
        chk("rst_wr_count", bus.wr_count, 0);
        chk("rst_err", bus.err, 0);

        // Idle for 100 cycles
        repeat (100) @(negedge clk);
        chk("idle_no_we", we_cnt, 0);
        chk("idle_cpu_hold", bus.cpu_hold, 1);
        chk("idle_disp", bus.disp_data, 0);

        // Glitch shorter than the debounce window
        bus.btn_write = 1'b1;
        repeat (DEB - 2) @(negedge clk);
        bus.btn_write = 1'b0;
        repeat (40) @(negedge clk);
        chk("glitch_no_we", we_cnt, 0);

        // Held press: event 19 cycles after the rise, mem_we one cycle later
        bus.btn_write = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.mem_we && lat < 0) lat = i;
        end
        bus.btn_write = 1'b0;
        repeat (25) @(negedge clk);
        chk("write_latency", lat, 20);
        chk("held_one_we", we_cnt, 1);

        // Table-driven address/write presses from a fresh reset
        vecs[0] = '{OP_ADDR,  32'h0000_0005, 6'd5,  33'h0_0000_000B, 7'd0, 6'd0,  32'h0};
        vecs[1] = '{OP_WRITE, 32'hDEAD_BEEF, 6'd6,  33'h1_BD5B_7DDF, 7'd1, 6'd5,  32'hDEAD_BEEF};
        vecs[2] = '{OP_WRITE, 32'h0000_1234, 6'd7,  33'h0_0000_2469, 7'd2, 6'd6,  32'h0000_1234};
        vecs[3] = '{OP_ADDR,  32'hFFFF_FF3F, 6'd63, 33'h0_0000_007F, 7'd2, 6'd0,  32'h0};
        vecs[4] = '{OP_WRITE, 32'hCAFE_0002, 6'd0,  33'h1_95FC_0005, 7'd3, 6'd63, 32'hCAFE_0002};
        vecs[5] = '{OP_ADDR,  32'h0000_00AA, 6'd42, 33'h0_0000_0055, 7'd3, 6'd0,  32'h0};
        do_reset();
        for (int v = 0; v < 6; v++) begin
            press(vecs[v].op, vecs[v].sw);
            chk($sformatf("vec%0d_addr", v), bus.mem_addr, vecs[v].exp_addr);
            chk($sformatf("vec%0d_disp", v), bus.disp_data, vecs[v].exp_disp);
            chk($sformatf("vec%0d_wr_count", v), bus.wr_count, vecs[v].exp_cnt);
            if (vecs[v].op == OP_WRITE)
                chk($sformatf("vec%0d_mem", v), mem[vecs[v].mem_idx], vecs[v].mem_val);
        end
        chk("table_err", bus.err, 0);
        chk("we_single_cycle", we_wide, 0);

        // 65 more writes: every one performed, count stops at 64
        we_base = we_cnt;
        for (int n = 0; n < 65; n++) press(1, n * 4);
        chk("sat_wr_count", bus.wr_count, 64);
        chk("sat_we_pulses", we_cnt - we_base, 65);
        chk("sat_addr_wrap", bus.mem_addr, (42 + 65) % 64);

        // Run and write in the same cycle: run wins, later presses ignored
        we_base = we_cnt;
        @(negedge clk);
        set_btns(1'b0, 1'b1, 1'b1);
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (!bus.cpu_hold && lat < 0) lat = i;
        end
        set_btns(1'b0, 1'b0, 1'b0);
        repeat (25) @(negedge clk);
        chk("run_latency", lat, 20);
        chk("run_no_write", we_cnt - we_base, 0);
        press(1, 32'h1111_1111);
        press(0, 32'h0000_0003);
        chk("run_ignore_we", we_cnt - we_base, 0);
        chk("run_ignore_addr", bus.mem_addr, (42 + 65) % 64);
        chk("run_cpu_hold", bus.cpu_hold, 0);
        do_reset();
        chk("run_rst_hold", bus.cpu_hold, 1);
        chk("run_rst_count", bus.wr_count, 0);

        // Reset while the write strobe is high
        @(negedge clk);
        bus.btn_write = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            @(negedge clk);
            if (bus.mem_we) lat = i;
        end
        chk("rstw_saw_we", lat > 0, 1);
        rst = 1'b1;
        set_btns(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rstw_we_low", bus.mem_we, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstw_count", bus.wr_count, 0);
        chk("rstw_addr", bus.mem_addr, 0);

        // Readback against a memory that drops bit 0
        corrupt = 1'b1;
        press(1, 32'h0000_0001);
`ifdef LOADER_READBACK_EN
        chk("rb_err_set", bus.err, 1);
        press(1, 32'h0000_0002);
        chk("rb_err_sticky", bus.err, 1);
        chk("rb_addr", bus.mem_addr, 2);
        chk("rb_count", bus.wr_count, 2);
        do_reset();
        chk("rb_err_cleared", bus.err, 0);
`else
        chk("norb_err_tied", bus.err, 0);
        chk("norb_addr", bus.mem_addr, 1);
`endif
        corrupt = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
